// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch-side prediction and MEM-side training signals
interface branch_predictor_if #(
  parameter int IDX_BITS = 5
);
  logic [31:0]         if_pc;
  logic                pred_hit;
  logic                pred_taken;
  logic [31:0]         pred_target;
  logic [31:0]         pred_next_pc;
  logic [IDX_BITS-1:0] pred_idx;
  logic                upd_valid;
  logic [31:0]         upd_pc;
  logic                upd_taken;
  logic [31:0]         upd_target;
  logic [IDX_BITS-1:0] upd_idx;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_idx,
    input  pred_hit, pred_taken, pred_target, pred_next_pc, pred_idx
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_idx,
    output pred_hit, pred_taken, pred_target, pred_next_pc, pred_idx
  );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped tagged BTB plus gshare PHT next-PC predictor
module branch_predictor #(
  parameter int IDX_BITS  = 5,
  parameter int HIST_BITS = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  branch_predictor_if.slave  bp
);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef logic [TAG_BITS-1:0] tag_t;

  logic [ENTRIES-1:0]   valid_q, valid_d;
  tag_t                 tag_q    [ENTRIES];
  tag_t                 tag_d    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [31:0]          target_d [ENTRIES];
  logic [1:0]           pht_q    [ENTRIES];
  logic [1:0]           pht_d    [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  logic [IDX_BITS-1:0]  if_bi, upd_bi;
  tag_t                 if_tag, upd_tag;
  logic [HIST_BITS:0]   ghr_shift;

  assign if_bi   = bp.if_pc[IDX_BITS+1:2];
  assign if_tag  = bp.if_pc[31:IDX_BITS+2];
  assign upd_bi  = bp.upd_pc[IDX_BITS+1:2];
  assign upd_tag = bp.upd_pc[31:IDX_BITS+2];

  // Prediction reads stored state only; an update in flight is seen next cycle.
  assign bp.pred_idx     = if_bi ^ IDX_BITS'(ghr_q);
  assign bp.pred_hit     = valid_q[if_bi] && (tag_q[if_bi] == if_tag);
  assign bp.pred_taken   = bp.pred_hit && pht_q[bp.pred_idx][1];
  assign bp.pred_target  = bp.pred_hit ? target_q[if_bi] : 32'd0;
  assign bp.pred_next_pc = bp.pred_taken ? bp.pred_target : bp.if_pc + 32'd4;

  assign ghr_shift = {ghr_q, bp.upd_taken};

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    pht_d    = pht_q;
    ghr_d    = ghr_q;
    if (bp.upd_valid) begin
      // upd_idx is the index used at fetch; history has moved on since then.
      if (bp.upd_taken) begin
        if (pht_q[bp.upd_idx] != 2'd3) begin
          pht_d[bp.upd_idx] = pht_q[bp.upd_idx] + 2'd1;
        end
        valid_d[upd_bi]  = 1'b1;
        tag_d[upd_bi]    = upd_tag;
        target_d[upd_bi] = bp.upd_target;
      end else if (pht_q[bp.upd_idx] != 2'd0) begin
        pht_d[bp.upd_idx] = pht_q[bp.upd_idx] - 2'd1;
      end
      ghr_d = ghr_shift[HIST_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      ghr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        pht_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      pht_q    <= pht_d;
      ghr_q    <= ghr_d;
    end
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage next-PC predictor for the 5-stage RISC-V pipeline: a direct-mapped tagged BTB plus a gshare pattern history table (PHT) of 2-bit saturating counters.
- Produces the hit, prediction and target that are carried down the pipeline to MEM. There the hazard unit compares them against the resolved outcome to decide a flush.
- Trained non-speculatively from the MEM stage on every resolved branch or jump.

Parameters:
IDX_BITS, 5, log2 of entry count for both BTB and PHT (32 entries)
HIST_BITS, 5, global history register width; must be <= IDX_BITS

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
if_pc  input  32  PC of instruction currently being fetched
pred_hit  output  1  BTB tag match with valid entry for if_pc
pred_taken  output  1  predicted taken (pred_hit && counter MSB)
pred_target  output  32  BTB target for if_pc (0 when !pred_hit)
pred_next_pc  output  32  pred_taken ? pred_target : if_pc+4
pred_idx  output  IDX_BITS  PHT index used for this prediction; piped to MEM
upd_valid  input  1  MEM holds a branch or jump resolving this cycle
upd_pc  input  32  PC of resolving instruction
upd_taken  input  1  resolved direction (branch taken OR any jump)
upd_target  input  32  resolved target address
upd_idx  input  IDX_BITS  pred_idx captured when this instruction was fetched

Behaviour:
- Storage:
  - BTB entry = valid, tag = pc[31:IDX_BITS+2], target[31:0]; BTB index bi = pc[IDX_BITS+1:2].
  - PHT entry = 2-bit counter.
  - GHR is HIST_BITS wide.
- Prediction is combinational from stored state (no bypass):
  - pred_idx = if_pc[IDX_BITS+1:2] XOR zero-extended GHR.
  - pred_hit = valid[bi] && tag[bi]==if_pc[31:IDX_BITS+2].
  - pred_taken = pred_hit && pht[pred_idx][1].
  - pred_target = pred_hit ? btb_target[bi] : 0.
  - pred_next_pc as defined in Ports; if_pc+4 is a 32-bit add that wraps.
- Reset (synchronous, reset_n==0 at posedge clk):
  - All BTB valid bits cleared; targets and tags set to 0.
  - All PHT counters set to 2'b01 (weakly not-taken); GHR = 0.
  - The first cycle after reset gives pred_hit=0, pred_taken=0, pred_target=0, pred_next_pc=if_pc+4.
  - Reset overrides any concurrent upd_valid: no update occurs.
- Update, at posedge clk when reset_n==1 and upd_valid==1:
  - PHT[upd_idx]: increment if upd_taken, else decrement; saturates at 3 and 0.
  - BTB[upd_pc bi]: if upd_taken, write valid=1, tag, target=upd_target, overwriting any alias. If not taken, BTB untouched.
  - GHR <= {GHR[HIST_BITS-2:0], upd_taken}; oldest bit dropped.
  - Index the PHT with upd_idx, not a recomputed index; history has moved since fetch.
- Latency:
  - An update is visible to prediction on the cycle after the update edge.
  - A same-cycle read of the entry being written returns the old value.
- upd_valid==0: no state changes. No stall input; the block has no pipeline registers of its own, and stall/flush handling of pred_* belongs to the IF/ID registers.
- Flush from the hazard unit does not roll back GHR; history is committed only at MEM.

Test Plan:
- Reset then if_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0, pred_next_pc=0x0000_0044, pred_idx=0x10.
- One update: upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_idx=0x10. Next cycle if_pc=0x40 -> pred_hit=1, target=0x100, GHR=00001, pred_idx=0x11. PHT[0x10] becomes 2, but PHT[0x11]=1, so pred_taken=0 and pred_next_pc=0x44.
- Five taken updates to upd_idx=3, then a sixth -> counter holds at 3. Three not-taken updates -> counter 0; a fourth holds at 0; pred_taken=0.
- Aliasing: taken update at upd_pc=0x40 (target 0x100), then taken at 0x0000_00C0 (same bi, target 0x200) -> if_pc=0x40 gives pred_hit=0; if_pc=0xC0 gives pred_hit=1, target=0x200.
- Not-taken update to an unseen pc=0x80 -> BTB stays invalid; only PHT and GHR change (GHR shifts in 0).
- Mid-run reset: reset_n=0 while upd_valid=1 -> after the edge, all entries invalid, all counters 01, GHR=0, update discarded.
